// File: rtl/bufferm_pkg.sv
// Shared definitions for the runtime-writable meta buffer loader.
// Holds header field positions, default widths and FSM state encoding.
package bufferm_pkg;

   // Default geometry of one PE meta buffer and of the load stream
   localparam int ADDR_LEN  = 10;
   localparam int DATA_LEN  = 16;
   localparam int PE_ID_LEN = 6;

   // H0: last flag in the top bit, target PE in the low bits
   function automatic int last_bit(input int dlen);
      return dlen - 1;
   endfunction

   // H2: count needs one extra bit to express a full-depth load
   function automatic int cnt_width(input int alen);
      return alen + 1;
   endfunction

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      CNT   = 3'd2,
      WRITE = 3'd3,
      SKIP  = 3'd4
   } state_t;

endpackage

// File: rtl/bufferm_ram.sv
// Meta buffer storage: one write port, one read-first registered read port.
// Ports: i_clk, i_rst_n, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read).
module bufferm_ram
   import bufferm_pkg::*;
#(
   parameter int addrLen = ADDR_LEN,
   parameter int dataLen = DATA_LEN
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_we,
   input  logic [addrLen-1:0] i_waddr,
   input  logic [dataLen-1:0] i_wdata,
   input  logic [addrLen-1:0] i_raddr,
   output logic [dataLen-1:0] o_rdata
);

   logic [dataLen-1:0] r_mem [2**addrLen];
   logic [dataLen-1:0] r_rdata;

   // Storage is never reset so it can map onto block RAM
   always_ff @(posedge i_clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
   end

   // Same-edge read of the written address returns the old word
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_rdata <= '0;
      else
         r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/bufferm_loader.sv
// Per-PE meta buffer loaded from a shared packetized configuration stream.
// Ports: clk, reset (async active-low), ld_valid/ld_data/ld_ready (load
// stream), rd_addr/data_out (datapath read), loaded, ld_err (sticky flags).
module bufferm_loader
   import bufferm_pkg::*;
#(
   parameter int addrLen = ADDR_LEN,
   parameter int dataLen = DATA_LEN,
   parameter int peId    = 0,
   parameter int peIdLen = PE_ID_LEN
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ld_valid,
   input  logic [dataLen-1:0] ld_data,
   output logic               ld_ready,
   input  logic [addrLen-1:0] rd_addr,
   output logic [dataLen-1:0] data_out,
   output logic               loaded,
   output logic               ld_err
);

   localparam int CW = cnt_width(addrLen);
   localparam int LB = last_bit(dataLen);
   localparam logic [peIdLen-1:0] PE_ID = peIdLen'(peId);
   localparam logic [CW-1:0] DEPTH = {1'b1, {addrLen{1'b0}}};

   state_t             r_state;
   logic               r_last;
   logic               r_match;
   logic [addrLen-1:0] r_base;
   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      r_idx;
   logic               r_ready;
   logic               r_loaded;
   logic               r_err;

   logic               w_acc;
   logic               w_we;
   logic               w_end;
   logic [CW-1:0]      w_cnt;
   logic [addrLen-1:0] w_waddr;

   assign w_acc   = ld_valid & r_ready;
   assign w_we    = w_acc & (r_state == WRITE);
   assign w_cnt   = ld_data[CW-1:0];
   assign w_end   = (r_idx == r_cnt - CW'(1));
   // Truncation gives the wrap-around at the top of the buffer
   assign w_waddr = r_base + r_idx[addrLen-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_last   <= 1'b0;
         r_match  <= 1'b0;
         r_base   <= '0;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_ready  <= 1'b0;
         r_loaded <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_ready <= 1'b1;
         if (w_acc) begin
            unique case (r_state)
               IDLE: begin
                  r_last  <= ld_data[LB];
                  r_match <= (ld_data[peIdLen-1:0] == PE_ID);
                  r_state <= ADDR;
               end
               ADDR: begin
                  r_base  <= ld_data[addrLen-1:0];
                  r_state <= CNT;
               end
               CNT: begin
                  r_cnt <= w_cnt;
                  r_idx <= '0;
                  if (w_cnt == '0) begin
                     r_state <= IDLE;
                     if (r_last && r_match)
                        r_loaded <= 1'b1;
                  end else if (w_cnt > DEPTH) begin
                     r_err   <= 1'b1;
                     r_state <= SKIP;
                  end else begin
                     r_state <= r_match ? WRITE : SKIP;
                  end
               end
               WRITE: begin
                  r_idx <= r_idx + CW'(1);
                  if (w_end) begin
                     r_state <= IDLE;
                     if (r_last)
                        r_loaded <= 1'b1;
                  end
               end
               SKIP: begin
                  r_idx <= r_idx + CW'(1);
                  if (w_end)
                     r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   bufferm_ram #(
      .addrLen (addrLen),
      .dataLen (dataLen)
   ) u_ram (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (ld_data),
      .i_raddr (rd_addr),
      .o_rdata (data_out)
   );

   assign ld_ready = r_ready;
   assign loaded   = r_loaded;
   assign ld_err   = r_err;

endmodule

// File: tb/tb_bufferm_loader.sv
// Directed bench for bufferm_loader (addrLen 10, dataLen 16, peId 0).
// Drives packets #1 after rising edges and samples #1 after rising edges.
module tb_bufferm_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ld_valid = 1'b0;
   logic [15:0] ld_data = '0;
   logic        ld_ready;
   logic [9:0]  rd_addr = '0;
   logic [15:0] data_out;
   logic        loaded;
   logic        ld_err;

   int n_vec = 0;
   int n_err = 0;

   bufferm_loader #(
      .addrLen (10),
      .dataLen (16),
      .peId    (0),
      .peIdLen (6)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_ready (ld_ready),
      .rd_addr  (rd_addr),
      .data_out (data_out),
      .loaded   (loaded),
      .ld_err   (ld_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] w);
      ld_valid = 1'b1;
      ld_data  = w;
      step();
      ld_valid = 1'b0;
   endtask

   task automatic gap(input int n);
      ld_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic rd(input logic [9:0] a, input logic [15:0] exp,
                     input string tag);
      rd_addr = a;
      step();
      chk(tag, data_out, exp);
   endtask

   task automatic hdr(input logic [15:0] h0, input logic [15:0] base,
                      input logic [15:0] cnt);
      send(h0);
      send(base);
      send(cnt);
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_dout"}, data_out, 16'h0);
      chk({tag, "_rdy"}, {15'd0, ld_ready}, 16'h0);
      chk({tag, "_ld"}, {15'd0, loaded}, 16'h0);
      chk({tag, "_err"}, {15'd0, ld_err}, 16'h0);
   endtask

   initial begin
      #3 reset = 1'b0;
      step();
      step();
      chk_rst("rst");
      reset = 1'b1;
      chk("rdy_pre", {15'd0, ld_ready}, 16'h0);
      step();
      chk("rdy_post", {15'd0, ld_ready}, 16'h1);

      // Known contents at 0..3, matching but not last
      hdr(16'h0000, 16'd0, 16'd4);
      send(16'h0A00); send(16'h0A01); send(16'h0A02); send(16'h0A03);
      chk("nolast_ld", {15'd0, loaded}, 16'h0);

      // Other PE, last: must not write nor set loaded
      hdr(16'h8001, 16'd0, 16'd4);
      send(16'hDEAD); send(16'hBEEF); send(16'hCAFE); send(16'hF00D);
      chk("other_ld", {15'd0, loaded}, 16'h0);

      // Immediately following matching last packet
      hdr(16'h8000, 16'd5, 16'd3);
      send(16'h0011); send(16'h0022);
      chk("ld_early", {15'd0, loaded}, 16'h0);
      send(16'h0033);
      chk("ld_set", {15'd0, loaded}, 16'h1);
      rd(10'd5, 16'h0011, "m5");
      rd(10'd6, 16'h0022, "m6");
      rd(10'd7, 16'h0033, "m7");
      for (int i = 0; i < 4; i++)
         rd(10'(i), 16'h0A00 + 16'(i), "other_keep");

      // Wrap-around at the top of the buffer
      hdr(16'h0000, 16'd1022, 16'd4);
      send(16'd1); send(16'd2); send(16'd3); send(16'd4);
      rd(10'd1022, 16'd1, "w1022");
      rd(10'd1023, 16'd2, "w1023");
      rd(10'd0, 16'd3, "w0");
      rd(10'd1, 16'd4, "w1");

      // Valid gaps during WRITE
      hdr(16'h0000, 16'd200, 16'd3);
      gap($urandom_range(0, 3));
      send(16'h1111);
      gap($urandom_range(1, 3));
      send(16'h2222);
      gap($urandom_range(1, 3));
      send(16'h3333);
      rd(10'd200, 16'h1111, "g200");
      rd(10'd201, 16'h2222, "g201");
      rd(10'd202, 16'h3333, "g202");

      // Read and write same address at the same edge
      hdr(16'h0000, 16'd201, 16'd2);
      rd_addr  = 10'd201;
      ld_valid = 1'b1;
      ld_data  = 16'h4444;
      step();
      ld_valid = 1'b0;
      chk("rf_old", data_out, 16'h2222);
      step();
      chk("rf_new", data_out, 16'h4444);
      send(16'h5555);
      rd(10'd202, 16'h5555, "rf_202");
      rd(10'd200, 16'h1111, "rf_200");

      // Oversize count: error, whole payload skipped
      hdr(16'h8000, 16'd0, 16'd1025);
      chk("err_set", {15'd0, ld_err}, 16'h1);
      for (int i = 0; i < 1025; i++) send(16'hFFFF);
      rd(10'd0, 16'd3, "err_m0");
      rd(10'd1, 16'd4, "err_m1");
      rd(10'd2, 16'h0A02, "err_m2");
      hdr(16'h0000, 16'd300, 16'd1);
      send(16'h7777);
      rd(10'd300, 16'h7777, "post_err");

      // Known contents at 400..404, then reset mid-packet
      hdr(16'h0000, 16'd400, 16'd5);
      for (int i = 0; i < 5; i++) send(16'h0400 + 16'(i));
      hdr(16'h8000, 16'd400, 16'd5);
      send(16'h0091); send(16'h0092);
      reset = 1'b0;
      #1;
      chk_rst("mid");
      step();
      reset = 1'b1;
      step();
      hdr(16'h8000, 16'd500, 16'd2);
      send(16'h00A1); send(16'h00A2);
      chk("re_ld", {15'd0, loaded}, 16'h1);
      rd(10'd500, 16'h00A1, "re500");
      rd(10'd501, 16'h00A2, "re501");
      rd(10'd400, 16'h0091, "ab400");
      rd(10'd401, 16'h0092, "ab401");
      rd(10'd402, 16'h0402, "ab402");
      rd(10'd403, 16'h0403, "ab403");
      rd(10'd404, 16'h0404, "ab404");
      chk("re_err", {15'd0, ld_err}, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
